// File: rtl/key_pio_in.sv
// Avalon-MM input PIO: synchronises, debounces and edge-captures WIDTH board
// inputs, raises a maskable level interrupt and serves 1-cycle registered reads.
module key_pio_in #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0]  ADDR_DATA = 2'd0;
  localparam logic [1:0]  ADDR_MASK = 2'd1;
  localparam logic [1:0]  ADDR_ECAP = 2'd2;
  localparam logic [15:0] CNT_LAST  = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_prev_q;
  logic [15:0]      cnt_q [WIDTH];
  logic [15:0]      cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ecap_q, ecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise, fall, edge_set, clear;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Each bit needs DEBOUNCE_CYCLES consecutive mismatching samples before deb follows.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = 16'd0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    rise = deb_q & ~deb_prev_q;
    fall = ~deb_q & deb_prev_q;
    case (EDGE_TYPE)
      0:       edge_set = rise;
      2:       edge_set = rise | fall;
      default: edge_set = fall;
    endcase
  end

  // Reads see register state from before any write landing on the same edge.
  always_comb begin
    clear  = (wr_en && address == ADDR_ECAP) ? wdata : '0;
    ecap_d = edge_set | (ecap_q & ~clear);
    mask_d = (wr_en && address == ADDR_MASK) ? wdata : mask_q;
    irq_d  = |(ecap_q & mask_q);
    case (address)
      ADDR_DATA: readdata_d = 32'(deb_q);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_ECAP: readdata_d = 32'(ecap_q);
      default:   readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      mask_q     <= '0;
      ecap_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      // NOTE: the counter array is small flop state, not RAM, so it is reset like any register.
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= in_port;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      mask_q     <= mask_d;
      ecap_q     <= ecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_key_pio_in.sv
// Bench for key_pio_in: directed register/debounce scenarios plus random traffic,
// all compared every cycle against a window-based behavioural model.
module tb_key_pio_in;
  localparam int W  = 10;
  localparam int D  = 4;
  localparam int ET = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = 32'd0;
  logic [W-1:0] in_port = '0;
  logic [31:0]  readdata;
  logic         irq;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  key_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(ET)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Model: samp[t] is in_port as sampled on edge t since reset (samp[0] fills edge 0).
  logic [W-1:0] samp [$];
  logic [W-1:0] m_deb, m_deb_prev, m_mask, m_ecap;
  logic [31:0]  m_rd;
  logic         m_irq;

  // The value the second sync stage presents to edge e: the input taken two edges earlier.
  function automatic logic [W-1:0] s2_seen(input int e);
    int idx = e - 2;
    if (idx >= 1 && idx < samp.size()) return samp[idx];
    return '0;
  endfunction

  task automatic model_reset();
    samp.delete();
    samp.push_back('0);
    m_deb      = '0;
    m_deb_prev = '0;
    m_mask     = '0;
    m_ecap     = '0;
    m_rd       = 32'd0;
    m_irq      = 1'b0;
  endtask

  task automatic model_edge();
    int           t;
    logic [W-1:0] flips, setv, clr;
    logic         wr;
    t = samp.size();
    // A bit follows its input once the last D synchronised samples all disagree with it.
    flips = '1;
    for (int k = 0; k < D; k++) flips &= s2_seen(t - k) ^ m_deb;
    case (ET)
      0:       setv = m_deb & ~m_deb_prev;
      2:       setv = m_deb ^ m_deb_prev;
      default: setv = ~m_deb & m_deb_prev;
    endcase
    wr  = chipselect && !write_n;
    clr = (wr && address == 2'd2) ? writedata[W-1:0] : '0;
    case (address)
      2'd0:    m_rd = 32'(m_deb);
      2'd1:    m_rd = 32'(m_mask);
      2'd2:    m_rd = 32'(m_ecap);
      default: m_rd = 32'd0;
    endcase
    m_irq  = |(m_ecap & m_mask);
    m_ecap = setv | (m_ecap & ~clr);
    if (wr && address == 2'd1) m_mask = writedata[W-1:0];
    m_deb_prev = m_deb;
    m_deb      = m_deb ^ flips;
    samp.push_back(in_port);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_edge();
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    d = readdata;
  endtask

  initial begin
    logic [31:0] r;
    #1;
    reset   = 1'b1;
    in_port = 10'h3FF;
    tick(2);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);

    // Inputs high through reset: DATA follows on edge 2+D, no falling capture.
    address = 2'd0;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      if (e == 6) check("data_before_debounce", readdata, 32'd0);
      if (e == 7) check("data_after_debounce", readdata, 32'h3FF);
    end
    bus_read(2'd2, r);
    check("ecap_after_reset_release", r, 32'd0);
    check("irq_after_reset_release", 32'(irq), 32'd0);

    // Clean fall of bit 3 with it unmasked.
    bus_write(2'd1, 32'h008);
    in_port = 10'h3F7;
    address = 2'd2;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 7) begin
        check("ecap_bit3_edge7", readdata, 32'd0);
        check("irq_bit3_edge7", 32'(irq), 32'd0);
      end
      if (e == 8) begin
        check("ecap_bit3_edge8", readdata, 32'h008);
        check("irq_bit3_edge8", 32'(irq), 32'd1);
      end
    end
    bus_write(2'd2, 32'h8);
    check("irq_hold_during_clear", 32'(irq), 32'd1);
    tick(1);
    check("irq_after_clear", 32'(irq), 32'd0);
    bus_read(2'd2, r);
    check("ecap_after_clear", r, 32'd0);

    // Low glitch of D-1 cycles on bit 0 must be rejected.
    bus_write(2'd1, 32'h009);
    in_port = 10'h3F6;
    tick(D - 1);
    in_port = 10'h3F7;
    tick(12);
    bus_read(2'd0, r);
    check("data_after_glitch", r, 32'h3F7);
    bus_read(2'd2, r);
    check("ecap_after_glitch", r, 32'd0);
    check("irq_after_glitch", 32'(irq), 32'd0);

    // Masked capture on bit 2, then unmask.
    bus_write(2'd1, 32'h000);
    in_port = 10'h3F3;
    tick(10);
    check("irq_masked", 32'(irq), 32'd0);
    bus_read(2'd2, r);
    check("ecap_bit2_masked", r, 32'h004);
    bus_write(2'd1, 32'h004);
    check("irq_on_unmask_edge", 32'(irq), 32'd0);
    tick(1);
    check("irq_after_unmask", 32'(irq), 32'd1);
    bus_write(2'd2, 32'h4);
    tick(1);
    check("irq_after_bit2_clear", 32'(irq), 32'd0);

    // Clear of bit 5 lands on the same edge its new fall is captured.
    in_port = 10'h3D3;
    tick(6);
    bus_write(2'd2, 32'h20);
    bus_read(2'd2, r);
    check("ecap_set_beats_clear", r, 32'h020);
    bus_write(2'd2, 32'h0);
    bus_read(2'd2, r);
    check("ecap_write_zero", r, 32'h020);

    // Reserved address and read-only DATA.
    bus_read(2'd3, r);
    check("reserved_read", r, 32'd0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd0, r);
    check("data_write_ignored", r, 32'h3D3);
    bus_read(2'd1, r);
    check("mask_readback", r, 32'h004);
    bus_read(2'd2, r);
    check("ecap_after_reserved_write", r, 32'h020);

    // Asynchronous reset while the interrupt is active.
    bus_write(2'd1, 32'h020);
    tick(2);
    check("irq_before_reset", 32'(irq), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("irq_async_reset", 32'(irq), 32'd0);
    check("readdata_async_reset", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(2'd1, r);
    check("mask_after_reset", r, 32'd0);
    bus_read(2'd2, r);
    check("ecap_after_reset", r, 32'd0);

    // Random traffic: bit toggles (some shorter than D) mixed with bus accesses.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(3) == 0) in_port = in_port ^ (10'(1) << $urandom_range(W - 1));
      address    = 2'($urandom_range(3));
      chipselect = ($urandom_range(2) == 0);
      write_n    = 1'($urandom_range(1));
      writedata  = $urandom;
      @(negedge clk);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
